// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared types for the instruction fetch stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   localparam word_t c_WORD_MASK = 32'hFFFF_FFFC;
   localparam word_t c_WORD_STEP = 32'h0000_0004;

   function automatic word_t word_align(input word_t a);
      return a & c_WORD_MASK;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : icache, hazard/EX and IF/ID signals around the fetch stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic  ihit_i;
   word_t iload_i;
   logic  iren_o;
   word_t iaddr_o;
   logic  stall_i;
   logic  redirect_i;
   word_t redirect_pc_i;
   logic  halt_i;
   logic  valid_o;
   word_t instr_o;
   word_t npc_o;

   modport fu (
      input  ihit_i, iload_i, stall_i, redirect_i, redirect_pc_i, halt_i,
      output iren_o, iaddr_o, valid_o, instr_o, npc_o
   );

   modport ic (
      output ihit_i, iload_i,
      input  iren_o, iaddr_o
   );

   modport hu (
      output stall_i, redirect_i, redirect_pc_i, halt_i,
      input  valid_o, instr_o, npc_o
   );

endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC owner, icache requester and IF/ID presenter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  wire logic CLK,
   input  wire logic RST,
   fetch_unit_if.fu  bus
);

   fetch_state_t r_state, w_state;
   word_t        r_pc, w_pc;
   word_t        r_buf_instr, w_buf_instr;
   word_t        r_buf_npc, w_buf_npc;
   word_t        r_pend_pc, w_pend_pc;

   word_t        w_pc_inc;
   word_t        w_target;
   word_t        w_drain_target;

   assign w_pc_inc       = r_pc + c_WORD_STEP;
   assign w_target       = word_align(bus.redirect_pc_i);
   // A redirect arriving while draining overrides the earlier pending target.
   assign w_drain_target = bus.redirect_i ? w_target : r_pend_pc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= FETCH;
         r_pc        <= PC_INIT;
         r_buf_instr <= '0;
         r_buf_npc   <= '0;
         r_pend_pc   <= '0;
      end else begin
         r_state     <= w_state;
         r_pc        <= w_pc;
         r_buf_instr <= w_buf_instr;
         r_buf_npc   <= w_buf_npc;
         r_pend_pc   <= w_pend_pc;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_pc        = r_pc;
      w_buf_instr = r_buf_instr;
      w_buf_npc   = r_buf_npc;
      w_pend_pc   = r_pend_pc;

      if (bus.halt_i) begin
         w_state = HALTED;
      end else begin
         case (r_state)
            FETCH: begin
               if (bus.redirect_i) begin
                  if (bus.ihit_i) begin
                     w_pc = w_target;
                  end else begin
                     // The miss stays outstanding; keep iaddr until it lands.
                     w_pend_pc = w_target;
                     w_state   = DRAIN;
                  end
               end else if (bus.ihit_i) begin
                  w_pc = w_pc_inc;
                  if (bus.stall_i) begin
                     w_buf_instr = bus.iload_i;
                     w_buf_npc   = w_pc_inc;
                     w_state     = HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.redirect_i) begin
                  w_pc    = w_target;
                  w_state = FETCH;
               end else if (!bus.stall_i) begin
                  w_state = FETCH;
               end
            end
            DRAIN: begin
               if (bus.ihit_i) begin
                  w_pc    = w_drain_target;
                  w_state = FETCH;
               end else begin
                  w_pend_pc = w_drain_target;
               end
            end
            HALTED: begin
               w_state = HALTED;
            end
            default: begin
               w_state = FETCH;
            end
         endcase
      end
   end

   always_comb begin
      bus.iren_o  = 1'b0;
      bus.iaddr_o = r_pc;
      bus.valid_o = 1'b0;
      bus.instr_o = '0;
      bus.npc_o   = '0;

      case (r_state)
         FETCH: begin
            bus.iren_o  = 1'b1;
            bus.valid_o = bus.ihit_i & ~bus.redirect_i;
            bus.instr_o = bus.iload_i;
            bus.npc_o   = w_pc_inc;
         end
         HOLD: begin
            bus.valid_o = 1'b1;
            bus.instr_o = r_buf_instr;
            bus.npc_o   = r_buf_npc;
         end
         DRAIN: begin
            bus.iren_o = 1'b1;
         end
         default: begin
            bus.iren_o = 1'b0;
         end
      endcase

      if (RST) begin
         bus.iren_o  = 1'b0;
         bus.valid_o = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed plus randomized checks against a behavioural model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam word_t c_PC_INIT = 32'h0000_0200;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fetch_unit_if bus();

   fetch_unit #(.PC_INIT(c_PC_INIT)) u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: architectural view of the fetch stream.
   word_t m_pc       = c_PC_INIT;
   bit    m_halted   = 1'b0;
   bit    m_have_buf = 1'b0;
   word_t m_buf_instr = '0;
   word_t m_buf_npc   = '0;
   bit    m_squash   = 1'b0;
   word_t m_tgt      = '0;

   task automatic chk(input string tag, input word_t got, input word_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic word_t mem(input word_t a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic step(input logic r, input logic h, input logic s, input logic rd,
                       input word_t t, input logic hl, input word_t ld);
      logic  e_iren, e_valid;
      word_t e_instr, e_npc, t_al, latest;
      rst               = r;
      bus.ihit_i        = h;
      bus.stall_i       = s;
      bus.redirect_i    = rd;
      bus.redirect_pc_i = t;
      bus.halt_i        = hl;
      bus.iload_i       = ld;
      #1;
      e_iren  = 1'b0;
      e_valid = 1'b0;
      e_instr = '0;
      e_npc   = '0;
      if (m_halted) begin
         e_iren = 1'b0;
      end else if (m_have_buf) begin
         e_valid = 1'b1;
         e_instr = m_buf_instr;
         e_npc   = m_buf_npc;
      end else if (m_squash) begin
         e_iren = 1'b1;
      end else begin
         e_iren  = 1'b1;
         e_valid = h & ~rd;
         e_instr = ld;
         e_npc   = m_pc + 32'd4;
      end
      if (r) begin
         e_iren  = 1'b0;
         e_valid = 1'b0;
      end
      chk("iren", 32'(bus.iren_o), 32'(e_iren));
      chk("valid", 32'(bus.valid_o), 32'(e_valid));
      if (e_iren) chk("iaddr", bus.iaddr_o, m_pc);
      if (e_valid || (m_halted && !r)) begin
         chk("instr", bus.instr_o, e_instr);
         chk("npc", bus.npc_o, e_npc);
      end
      @(posedge clk);
      t_al = {t[31:2], 2'b00};
      if (r) begin
         m_pc = c_PC_INIT; m_halted = 0; m_have_buf = 0; m_squash = 0;
      end else if (hl) begin
         m_halted = 1;
      end else if (m_halted) begin
         m_halted = 1;
      end else if (m_have_buf) begin
         if (rd) begin m_pc = t_al; m_have_buf = 0; end
         else if (!s) m_have_buf = 0;
      end else if (m_squash) begin
         latest = rd ? t_al : m_tgt;
         if (h) begin m_pc = latest; m_squash = 0; end
         else m_tgt = latest;
      end else if (rd) begin
         if (h) m_pc = t_al;
         else begin m_squash = 1; m_tgt = t_al; end
      end else if (h) begin
         if (s) begin
            m_have_buf = 1; m_buf_instr = ld; m_buf_npc = m_pc + 32'd4;
         end
         m_pc = m_pc + 32'd4;
      end
      #1;
   endtask

   task automatic fstep(input logic h, input logic s, input logic rd, input word_t t);
      step(1'b0, h, s, rd, t, 1'b0, mem(m_pc));
   endtask

   initial begin
      int halt_age;
      @(posedge clk);
      #1;
      // Reset and streaming hits from PC_INIT
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      chk("plan_reset_addr", bus.iaddr_o, 32'h200);
      for (int i = 0; i < 3; i++) fstep(1'b1, 1'b0, 1'b0, '0);
      chk("plan_stream_addr", bus.iaddr_o, 32'h20C);

      // Stall on a hit at 0x10
      fstep(1'b1, 1'b0, 1'b1, 32'h10);
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) fstep(1'b0, 1'b1, 1'b0, '0);
      fstep(1'b0, 1'b0, 1'b0, '0);
      chk("plan_stall_resume", bus.iaddr_o, 32'h14);

      // Redirect under an outstanding miss
      fstep(1'b1, 1'b0, 1'b1, 32'h40);
      fstep(1'b0, 1'b0, 1'b1, 32'h80);
      fstep(1'b0, 1'b0, 1'b0, '0);
      chk("plan_drain_hold", bus.iaddr_o, 32'h40);
      fstep(1'b1, 1'b0, 1'b0, '0);
      chk("plan_drain_target", bus.iaddr_o, 32'h80);

      // Same-cycle redirect and hit, then redirect during HOLD
      fstep(1'b1, 1'b0, 1'b1, 32'h20);
      fstep(1'b1, 1'b0, 1'b1, 32'h100);
      chk("plan_same_cycle", bus.iaddr_o, 32'h100);
      fstep(1'b1, 1'b1, 1'b0, '0);
      fstep(1'b0, 1'b1, 1'b1, 32'h300);
      chk("plan_hold_redirect", bus.iaddr_o, 32'h300);

      // Halt with a simultaneous redirect, then reset
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1, 32'h1234_5678);
      for (int i = 0; i < 4; i++) fstep(1'b1, 1'b0, 1'b1, 32'h600);
      chk("plan_halt_pc", bus.iaddr_o, 32'h300);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      fstep(1'b0, 1'b0, 1'b0, '0);
      chk("plan_halt_reset", bus.iaddr_o, 32'h200);

      // Address wrap and redirect alignment
      fstep(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      fstep(1'b1, 1'b0, 1'b0, '0);
      chk("plan_wrap", bus.iaddr_o, 32'h0);
      fstep(1'b1, 1'b0, 1'b1, 32'h103);
      chk("plan_align", bus.iaddr_o, 32'h100);

      // Randomized traffic
      halt_age = 0;
      for (int i = 0; i < 4000; i++) begin
         logic  r, h, s, rd, hl;
         word_t t;
         r  = (m_halted && halt_age > 4) || ($urandom_range(0, 299) == 0);
         h  = $urandom_range(0, 1) == 1;
         s  = $urandom_range(0, 2) == 0;
         rd = $urandom_range(0, 7) == 0;
         hl = $urandom_range(0, 149) == 0;
         t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                          : 32'($urandom);
         halt_age = m_halted ? halt_age + 1 : 0;
         step(r, h, s, rd, t, hl, mem(m_pc));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
